// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset core: sequences fetch, decode,
// execute, memory and writeback over one shared single-port memory.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       ir_opcode,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_write,
   output logic [1:0]       imm_sel,
   output logic             alu_src_a,
   output logic             alu_src_b,
   output logic [1:0]       alu_op,
   output logic             wb_sel,
   output logic             reg_write,
   output logic             pc_write,
   output logic             pc_sel,
   output logic             instr_done,
   output logic             trap,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      MEM       = 3'd4,
      WRITEBACK = 3'd5,
      TRAP      = 3'd6
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   state_t     state;
   logic       is_op, is_op_imm, is_load, is_store, is_branch, is_lui, is_legal;
   logic [1:0] imm_fmt;

   assign is_op     = (ir_opcode == OPC_OP);
   assign is_op_imm = (ir_opcode == OPC_OP_IMM);
   assign is_load   = (ir_opcode == OPC_LOAD);
   assign is_store  = (ir_opcode == OPC_STORE);
   assign is_branch = (ir_opcode == OPC_BRANCH);
   assign is_lui    = (ir_opcode == OPC_LUI);
   assign is_legal  = is_op | is_op_imm | is_load | is_store | is_branch | is_lui;

   // IR is stable from DECODE until retirement, so the format can be decoded live.
   assign imm_fmt = is_store  ? 2'b01 :
                    is_branch ? 2'b10 :
                    is_lui    ? 2'b11 : 2'b00;

   assign state_dbg = state;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; reset here is synchronous, sampled on the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         instret <= '0;
      end else begin
         if (instr_done) instret <= instret + CNT_W'(1);
         unique case (state)
            IDLE:      state <= FETCH;
            FETCH:     if (mem_ready) state <= DECODE;
            DECODE:    state <= is_legal ? EXECUTE : TRAP;
            EXECUTE: begin
               if (is_branch)                 state <= FETCH;
               else if (is_load || is_store)  state <= MEM;
               else                           state <= WRITEBACK;
            end
            MEM:       if (mem_ready) state <= is_store ? FETCH : WRITEBACK;
            WRITEBACK: state <= FETCH;
            TRAP:      state <= TRAP;
            default:   state <= IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_write   = 1'b0;
      imm_sel    = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = 2'b00;
      wb_sel     = 1'b0;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = 1'b0;
      instr_done = 1'b0;
      trap       = 1'b0;
      unique case (state)
         FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
         end
         DECODE: imm_sel = imm_fmt;
         EXECUTE: begin
            imm_sel = imm_fmt;
            if (is_branch) begin
               alu_op     = 2'b01;
               pc_write   = 1'b1;
               pc_sel     = branch_taken;
               instr_done = 1'b1;
            end else if (is_op || is_op_imm) begin
               alu_src_b = is_op_imm;
               alu_op    = 2'b10;
            end else begin
               alu_src_a = is_lui;
               alu_src_b = 1'b1;
            end
         end
         MEM: begin
            imm_sel  = imm_fmt;
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = is_store;
            if (mem_ready && is_store) begin
               pc_write   = 1'b1;
               instr_done = 1'b1;
            end
         end
         WRITEBACK: begin
            imm_sel    = imm_fmt;
            reg_write  = 1'b1;
            wb_sel     = is_load;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         TRAP:    trap = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven instruction vectors with
// a per-cycle expected-output scoreboard, plus reset and trap corner sequences.
module tb_multicycle_ctrl;

   localparam int CNT_W_TB = 3;

   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                          S_EXECUTE = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [6:0]          ir_opcode;
   logic                branch_taken;
   logic                mem_ready;
   logic                mem_req, mem_we, addr_sel, ir_write;
   logic [1:0]          imm_sel;
   logic                alu_src_a, alu_src_b;
   logic [1:0]          alu_op;
   logic                wb_sel, reg_write, pc_write, pc_sel, instr_done, trap;
   logic [CNT_W_TB-1:0] instret;
   logic [2:0]          state_dbg;

   multicycle_ctrl #(.CNT_W(CNT_W_TB)) dut (
      .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
      .ir_write(ir_write), .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .wb_sel(wb_sel), .reg_write(reg_write), .pc_write(pc_write),
      .pc_sel(pc_sel), .instr_done(instr_done), .trap(trap), .instret(instret),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req, mem_we, addr_sel, ir_write;
      logic [1:0] imm_sel;
      logic       src_a, src_b;
      logic [1:0] alu_op;
      logic       wb_sel, reg_write, pc_write, pc_sel, instr_done, trap;
   } obs_t;

   typedef struct packed {
      logic [6:0] opcode;
      logic       taken;
      logic [1:0] fwait, mwait;
      logic [1:0] imm;
      logic       src_a, src_b;
      logic [1:0] alu_op;
      logic       br, mem, store, wb, wb_sel;
   } vec_t;

   int                  checks = 0;
   int                  errors = 0;
   logic [CNT_W_TB-1:0] exp_instret;
   obs_t                exp_q[$];
   string               tag;
   vec_t                tbl[8];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.st = state_dbg;   o.mem_req = mem_req;     o.mem_we = mem_we;
      o.addr_sel = addr_sel; o.ir_write = ir_write; o.imm_sel = imm_sel;
      o.src_a = alu_src_a; o.src_b = alu_src_b;    o.alu_op = alu_op;
      o.wb_sel = wb_sel;  o.reg_write = reg_write; o.pc_write = pc_write;
      o.pc_sel = pc_sel;  o.instr_done = instr_done; o.trap = trap;
      return o;
   endfunction

   function automatic obs_t blank(input logic [2:0] st);
      obs_t o = '0;
      o.st = st;
      return o;
   endfunction

   // One clock cycle: drive mem_ready, queue the expectation, compare at negedge.
   task automatic cyc(input logic ready, input obs_t e);
      obs_t got, exp;
      mem_ready = ready;
      exp_q.push_back(e);
      @(negedge clk);
      got = sample();
      exp = exp_q.pop_front();
      check($sformatf("%s st%0d outputs", tag, exp.st), 64'(got), 64'(exp));
      check($sformatf("%s st%0d instret", tag, exp.st), 64'(instret), 64'(exp_instret));
      if (exp.instr_done) exp_instret++;
      @(posedge clk);
      #1;
   endtask

   // After reset release: IDLE cycles must be all-zero, then FETCH within a bound.
   task automatic wait_fetch();
      obs_t got, e;
      bit   found = 0;
      int   idle_cnt = 0;
      mem_ready = 1'b0;
      for (int n = 0; n < 6 && !found; n++) begin
         @(negedge clk);
         got = sample();
         check($sformatf("%s post-reset instret", tag), 64'(instret), 64'(exp_instret));
         if (got.st == S_FETCH) begin
            e = blank(S_FETCH);
            e.mem_req = 1'b1;
            check($sformatf("%s first fetch", tag), 64'(got), 64'(e));
            found = 1;
         end else begin
            check($sformatf("%s idle outputs", tag), 64'(got), 64'(blank(S_IDLE)));
            idle_cnt++;
         end
         @(posedge clk);
         #1;
      end
      check($sformatf("%s idle seen", tag), 64'(idle_cnt != 0), 64'(1));
      if (!found) check($sformatf("%s fetch timeout", tag), 64'(0), 64'(1));
   endtask

   task automatic fetch(input logic [1:0] fwait);
      obs_t e = blank(S_FETCH);
      e.mem_req = 1'b1;
      for (int i = 0; i < int'(fwait); i++) cyc(1'b0, e);
      e.ir_write = 1'b1;
      cyc(1'b1, e);
   endtask

   task automatic run_instr(input vec_t v);
      obs_t e;
      branch_taken = v.taken;
      fetch(v.fwait);
      ir_opcode = v.opcode;
      e = blank(S_DECODE);
      e.imm_sel = v.imm;
      cyc(1'b1, e);
      e = blank(S_EXECUTE);
      e.imm_sel = v.imm; e.src_a = v.src_a; e.src_b = v.src_b; e.alu_op = v.alu_op;
      if (v.br) begin
         e.pc_write = 1'b1; e.pc_sel = v.taken; e.instr_done = 1'b1;
      end
      cyc(1'b1, e);
      if (v.mem) begin
         e = blank(S_MEM);
         e.imm_sel = v.imm; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = v.store;
         for (int i = 0; i < int'(v.mwait); i++) cyc(1'b0, e);
         if (v.store) begin
            e.pc_write = 1'b1; e.instr_done = 1'b1;
         end
         cyc(1'b1, e);
      end
      if (v.wb) begin
         e = blank(S_WB);
         e.imm_sel = v.imm; e.reg_write = 1'b1; e.wb_sel = v.wb_sel;
         e.pc_write = 1'b1; e.instr_done = 1'b1;
         cyc(1'b1, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t e;
      //          opcode       tk    fw    mw    imm    a     b     aluop  br    mem   st    wb    wbs
      tbl[0] = '{7'b0010011, 1'b0, 2'd0, 2'd0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // ADDI
      tbl[1] = '{7'b0100011, 1'b0, 2'd0, 2'd2, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // SW
      tbl[2] = '{7'b1100011, 1'b1, 2'd0, 2'd0, 2'b10, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // BEQ taken
      tbl[3] = '{7'b1100011, 1'b0, 2'd0, 2'd0, 2'b10, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // BEQ not taken
      tbl[4] = '{7'b0000011, 1'b0, 2'd0, 2'd0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // LW
      tbl[5] = '{7'b0110111, 1'b0, 2'd0, 2'd0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // LUI
      tbl[6] = '{7'b0110011, 1'b0, 2'd1, 2'd0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // OP
      tbl[7] = '{7'b0000011, 1'b0, 2'd2, 2'd1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // LW waits

      rst_n = 1'b0; ir_opcode = 7'h00; branch_taken = 1'b0; mem_ready = 1'b1;
      exp_instret = '0;
      tag = "reset";
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset outputs", 64'(sample()), 64'(blank(S_IDLE)));
      check("reset instret", 64'(instret), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_fetch();

      // Eight retirements wrap the 3-bit counter back to zero.
      for (int i = 0; i < 8; i++) begin
         tag = $sformatf("vec%0d", i);
         run_instr(tbl[i]);
      end

      // Reset asserted during a MEM wait state of a store.
      tag = "rst_in_mem";
      branch_taken = 1'b0;
      run_instr(tbl[0]);
      fetch(2'd0);
      ir_opcode = tbl[1].opcode;
      e = blank(S_DECODE);  e.imm_sel = 2'b01;                 cyc(1'b1, e);
      e = blank(S_EXECUTE); e.imm_sel = 2'b01; e.src_b = 1'b1; cyc(1'b1, e);
      e = blank(S_MEM); e.imm_sel = 2'b01; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
      cyc(1'b0, e);
      rst_n = 1'b0;
      cyc(1'b0, e);
      rst_n = 1'b1;
      exp_instret = '0;
      wait_fetch();
      tag = "after_rst";
      run_instr(tbl[0]);

      // Illegal opcode traps permanently until reset.
      tag = "trap";
      fetch(2'd0);
      ir_opcode = 7'h7F;
      cyc(1'b1, blank(S_DECODE));
      e = blank(S_TRAP);
      e.trap = 1'b1;
      for (int i = 0; i < 20; i++) cyc(1'($urandom_range(0, 1)), e);
      rst_n = 1'b0;
      cyc(1'b1, e);
      rst_n = 1'b1;
      exp_instret = '0;
      wait_fetch();
      tag = "after_trap";
      run_instr(tbl[5]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
